// File: rtl/banco_regs_pkg.sv
// Shared types and defaults for the parametrised register bank and its dump engine.
package banco_regs_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } dump_state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;

  function automatic int depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/banco_regs_dump.sv
// Serial dump engine: walks every index once, presenting (addr, data) beats on a
// valid/ready stream. The beat data is captured from the storage read port when the beat is loaded.
module banco_regs_dump
  import banco_regs_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dump_start,
  input  logic              dump_ready,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output dump_state_t       dump_state
);

  // Stream handshake: a beat transfers on a rising edge where dump_valid && dump_ready.
  // While valid is high and ready is low, dump_addr and dump_data hold their values.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(depth(ADDR_W) - 1);

  dump_state_t state_q, state_d;
  logic        load, clear;

  assign dump_state = state_q;
  assign dump_last  = (dump_addr == LAST_IDX) && dump_valid;
  assign rd_addr    = (state_q == IDLE) ? '0 : dump_addr + ADDR_W'(1);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (dump_start) begin
          state_d = SEND;
          load    = 1'b1;
        end
      end
      SEND: begin
        if (dump_valid && dump_ready) begin
          if (dump_last) begin
            state_d = IDLE;
            clear   = 1'b1;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        dump_valid <= 1'b1;
        dump_addr  <= rd_addr;
        dump_data  <= rd_data;
      end else if (clear) begin
        dump_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/banco_regs_param.sv
// Parametrised register bank: two combinational read ports, one write port, serial dump.
// Define BANCO_REGS_BYPASS_EN for write-through forwarding on reads and dump capture.
module banco_regs_param
  import banco_regs_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last
);

  localparam int DEPTH = depth(ADDR_W);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_en;
  logic [ADDR_W-1:0] dump_rd_addr;
  logic [DATA_W-1:0] dump_rd_data;
  logic [DATA_W-1:0] s1, s2, sd;
  dump_state_t       dump_state;

  // Writes to index 0 are dropped when it is the hardwired zero register.
  assign wr_en = we3 && !((ZERO_REG != 0) && (wa3 == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wa3] <= wd3;
    end
  end

  assign s1 = ((ZERO_REG != 0) && (ra1 == '0)) ? '0 : regs[ra1];
  assign s2 = ((ZERO_REG != 0) && (ra2 == '0)) ? '0 : regs[ra2];
  assign sd = ((ZERO_REG != 0) && (dump_rd_addr == '0)) ? '0 : regs[dump_rd_addr];

`ifdef BANCO_REGS_BYPASS_EN
  assign rd1          = (wr_en && (ra1 == wa3)) ? wd3 : s1;
  assign rd2          = (wr_en && (ra2 == wa3)) ? wd3 : s2;
  assign dump_rd_data = (wr_en && (dump_rd_addr == wa3)) ? wd3 : sd;
`else
  assign rd1          = s1;
  assign rd2          = s2;
  assign dump_rd_data = sd;
`endif

  assign dump_busy = (dump_state == SEND);

  banco_regs_dump #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_dump (
    .clk       (clk),
    .rst       (rst),
    .dump_start(dump_start),
    .dump_ready(dump_ready),
    .dump_valid(dump_valid),
    .dump_addr (dump_addr),
    .dump_data (dump_data),
    .dump_last (dump_last),
    .rd_addr   (dump_rd_addr),
    .rd_data   (dump_rd_data),
    .dump_state(dump_state)
  );

endmodule

// File: tb/tb_banco_regs_param.sv
// Directed bench for banco_regs_param: reads, writes, zero register, same-cycle hazard,
// full dumps with and without backpressure, and reset during a dump.
module tb_banco_regs_param;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;
  localparam int ZR     = 1;
  localparam int BW     = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst, we3, dump_start, dump_ready;
  logic [ADDR_W-1:0] wa3, ra1, ra2;
  logic [DATA_W-1:0] wd3;
  logic [DATA_W-1:0] rd1, rd2, dump_data;
  logic              dump_busy, dump_valid, dump_last;
  logic [ADDR_W-1:0] dump_addr;

  int compared   = 0;
  int mismatched = 0;
  int beats      = 0;

  logic [BW-1:0]     exp_q[$];
  logic [DATA_W-1:0] model [DEPTH];

  banco_regs_param #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
    .ra1       (ra1),
    .ra2       (ra2),
    .rd1       (rd1),
    .rd2       (rd2),
    .dump_start(dump_start),
    .dump_busy (dump_busy),
    .dump_valid(dump_valid),
    .dump_ready(dump_ready),
    .dump_addr (dump_addr),
    .dump_data (dump_data),
    .dump_last (dump_last)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input int a, input int d);
    we3 = 1'b1;
    wa3 = ADDR_W'(a);
    wd3 = DATA_W'(d);
    if (!(ZR != 0 && a == 0)) model[a] = DATA_W'(d);
    tick();
    we3 = 1'b0;
  endtask

  task automatic push_dump();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({ADDR_W'(i), model[i]});
  endtask

  // scoreboard monitor: sample away from the rising edge
  logic              pend = 1'b0;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;
  always @(negedge clk) begin
    logic [BW-1:0] e;
    if (!rst) begin
      if (pend) begin
        check("hold_valid", dump_valid, 1);
        check("hold_addr", dump_addr, pend_addr);
        check("hold_data", dump_data, pend_data);
      end
      if (dump_valid) check("dump_last", dump_last, (dump_addr == ADDR_W'(DEPTH - 1)));
      if (dump_valid && dump_ready) begin
        beats++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {dump_addr, dump_data}, 0 - 1);
        end else begin
          e = exp_q.pop_front();
          check("beat", {dump_addr, dump_data}, e);
        end
      end
    end
    pend      = dump_valid && !dump_ready && !rst;
    pend_addr = dump_addr;
    pend_data = dump_data;
  end

  initial begin
    logic [DATA_W-1:0] hz;
    rst = 1'b1; we3 = 1'b0; wa3 = '0; wd3 = '0; ra1 = '0; ra2 = '0;
    dump_start = 1'b0; dump_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    tick();
    rst = 1'b0; ra1 = 3'd3; ra2 = 3'd5;
    #1;
    check("rst_rd1", rd1, 0);
    check("rst_rd2", rd2, 0);
    check("rst_valid", dump_valid, 0);
    check("rst_busy", dump_busy, 0);
    check("rst_addr", dump_addr, 0);
    check("rst_data", dump_data, 0);

    // write / read and zero register
    write_reg(2, 8'hA5);
    write_reg(0, 8'h3C);
    ra1 = 3'd2; ra2 = 3'd0;
    #1;
    check("rd_r2", rd1, 8'hA5);
    check("rd_r0", rd2, (ZR != 0) ? 8'h00 : 8'h3C);

    // same-cycle read of the address being written
    write_reg(4, 8'h11);
    we3 = 1'b1; wa3 = 3'd4; wd3 = 8'h77; ra1 = 3'd4;
    model[4] = 8'h77;
    #1;
`ifdef BANCO_REGS_BYPASS_EN
    hz = 8'h77;
`else
    hz = 8'h11;
`endif
    check("hazard_same", rd1, hz);
    tick();
    we3 = 1'b0;
    #1;
    check("hazard_next", rd1, 8'h77);

    // full dump, ready always high
    for (int i = 0; i < DEPTH; i++) write_reg(i, i);
    dump_ready = 1'b1;
    beats = 0;
    push_dump();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    #1;
    check("first_valid", dump_valid, 1);
    check("first_busy", dump_busy, 1);
    for (int c = 0; c < 40 && beats < DEPTH; c++) tick();
    check("dump1_beats", beats, DEPTH);
    check("dump1_busy_end", dump_busy, 0);
    check("dump1_valid_end", dump_valid, 0);
    check("dump1_q_empty", exp_q.size(), 0);

    // backpressure with a second start mid-dump
    write_reg(3, 8'hC3);
    write_reg(6, 8'h9E);
    beats = 0;
    dump_ready = 1'b0;
    push_dump();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int c = 0; c < 60 && beats < DEPTH; c++) begin
      dump_ready = c[0];
      dump_start = (c == 3);
      tick();
    end
    dump_start = 1'b0;
    dump_ready = 1'b1;
    #1;
    check("dump2_beats", beats, DEPTH);
    check("dump2_busy_end", dump_busy, 0);
    check("dump2_q_empty", exp_q.size(), 0);
    for (int c = 0; c < 5; c++) tick();
    check("dump2_no_extra", beats, DEPTH);

    // reset in the middle of a dump
    beats = 0;
    push_dump();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    tick();
    tick();
    dump_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    #1;
    check("mid_rst_valid", dump_valid, 0);
    check("mid_rst_busy", dump_busy, 0);
    check("mid_rst_addr", dump_addr, 0);
    check("mid_rst_data", dump_data, 0);
    for (int i = 0; i < DEPTH; i++) begin
      ra1 = ADDR_W'(i);
      ra2 = ADDR_W'(DEPTH - 1 - i);
      #1;
      check("mid_rst_rd1", rd1, model[i]);
      check("mid_rst_rd2", rd2, model[DEPTH - 1 - i]);
    end
    dump_ready = 1'b1;
    beats = 0;
    for (int c = 0; c < 5; c++) tick();
    check("mid_rst_no_beats", beats, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/banco_regs_param.md
Name: banco_regs_param

Overview:
- Parametrised successor to the 8×8 register bank: configurable data width and depth.
- Two combinational read ports and one synchronous write port; register 0 can optionally be hardwired to zero.
- Replaces the flat per-register debug outputs with a serial dump engine: a valid/ready stream of (address, data) beats used by the display/debug path.

Parameters:
- DATA_W, 8, register width in bits.
- ADDR_W, 3, address width; depth = 2**ADDR_W.
- ZERO_REG, 1, 1 = register 0 is never written and always reads 0; 0 = register 0 is an ordinary register.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- we3  in  1  write enable.
- wa3  in  ADDR_W  write address.
- wd3  in  DATA_W  write data.
- ra1  in  ADDR_W  read address, port 1.
- ra2  in  ADDR_W  read address, port 2.
- rd1  out  DATA_W  read data, port 1 (combinational).
- rd2  out  DATA_W  read data, port 2 (combinational).
- dump_start  in  1  one-cycle request to stream the whole file.
- dump_busy  out  1  dump engine active.
- dump_valid  out  1  beat valid.
- dump_ready  in  1  consumer accepts the beat.
- dump_addr  out  ADDR_W  index of the current beat.
- dump_data  out  DATA_W  captured register value.
- dump_last  out  1  current beat is index 2**ADDR_W-1.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All registers are cleared to 0.
  - FSM goes to IDLE.
  - dump_valid=0, dump_busy=0, dump_addr=0, dump_data=0.
  - rd1/rd2 therefore read 0 from the next cycle.
  - Reset overrides any write or dump in progress, including mid-dump; no further beats are produced.
- Write: at the edge, regs[wa3] <= wd3 if we3=1, unless ZERO_REG=1 and wa3=0, in which case the write is dropped.
- Read: rd1=regs[ra1] and rd2=regs[ra2], zero latency. With ZERO_REG=1, address 0 always returns 0.
- Same-cycle read of an address being written returns the OLD value (see Optional Feature).
- FSM states:
  - IDLE:
    - dump_start=1 → dump_addr<=0, dump_data<=regs[0], dump_valid<=1, go to SEND.
  - SEND:
    - dump_busy=1.
    - dump_valid is held and dump_addr/dump_data are stable until dump_valid && dump_ready.
    - On a handshake with dump_last=1 → dump_valid<=0, go to IDLE.
    - On a handshake with dump_last=0 → dump_addr<=dump_addr+1, dump_data<=regs[dump_addr+1], stay in SEND.
- Throughput is one beat per cycle while dump_ready=1. A full dump takes 2**ADDR_W beats; first valid appears 1 cycle after dump_start.
- dump_start while in SEND is ignored; no restart and no queuing.
- Data is captured when a beat is loaded. A write to an index already captured is not reflected in that beat.
- A write on the same edge as a capture of that index yields the pre-write value.
- dump_last is combinational: (dump_addr == 2**ADDR_W-1) && dump_valid.
- Index arithmetic is unsigned ADDR_W bits. The FSM never wraps: it exits after the last index.
- dump_busy = (state == SEND).

Optional Feature:
- Macro: BANCO_REGS_BYPASS_EN.
- Defined: write-through forwarding.
  - If we3=1 and the write is not dropped (per ZERO_REG), rd1/rd2 return wd3 whenever ra1/ra2 equals wa3.
  - A dump capture of index wa3 on that same edge also captures wd3.
- Undefined: old-value semantics as described in Behaviour.
- Register contents after the edge are identical either way.

Decomposition:
- Package banco_regs_pkg:
  - dump state enum {IDLE, SEND};
  - default DATA_W / ADDR_W localparams;
  - function for depth = 2**ADDR_W.
- Sub-module banco_regs_dump (the FSM, index counter and capture register). It takes a read-address output and a read-data input from the storage array.
- Storage, write logic and read ports stay in banco_regs_param.

Test Plan:
- Reset then reads: rst=1 for 1 cycle, ra1=3, ra2=5 → rd1=0, rd2=0, dump_valid=0, dump_busy=0.
- Write/read and zero register: write 8'hA5→r2, then 8'h3C→r0 → rd1(ra1=2)=A5; rd2(ra2=0)=00 with ZERO_REG=1, 3C with ZERO_REG=0.
- Same-cycle hazard: r4=11, then we3=1, wa3=4, wd3=77, ra1=4 in one cycle → rd1=11 without the macro, 77 with BANCO_REGS_BYPASS_EN; the following cycle rd1=77.
- Full dump with ready=1: regs r1..r7 = 1..7, pulse dump_start → 8 consecutive beats, addr 0..7, data 0..7, dump_last only on addr 7, then dump_busy=0 one cycle after the last handshake.
- Backpressure and restart: dump_ready toggled 0/1 every cycle, and dump_start pulsed again mid-dump → addr/data stable while ready=0; exactly 8 beats in order; second start ignored.
- Reset mid-dump: rst=1 during beat 3 → next cycle dump_valid=0, dump_busy=0, dump_addr=0, all regs read 0.
